// File: rtl/dino_collision_ctrl.sv
// Dino game-state controller. Runs the per-tick hitbox test against three danger
// slots, sequences IDLE/RUN/OVER, and keeps a saturating BCD score and high score.
module dino_collision_ctrl #(
  parameter int unsigned DINO_X    = 40,
  parameter int unsigned DINO_W    = 40,
  parameter int unsigned DINO_H    = 43,
  parameter int unsigned CACTUS_W  = 16,
  parameter int unsigned BIRD_W    = 32,
  parameter int unsigned BIRD_H    = 24,
  parameter int unsigned SCORE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_clk,
  input  logic        start,
  input  logic [8:0]  dino_pos,
  input  logic [8:0]  danger_pos1,
  input  logic [8:0]  danger_pos2,
  input  logic [8:0]  danger_pos3,
  input  logic [2:0]  danger_type1,
  input  logic [2:0]  danger_type2,
  input  logic [2:0]  danger_type3,
  input  logic        danger_en1,
  input  logic        danger_en2,
  input  logic        danger_en3,
  output logic        freeze,
  output logic        game_over,
  output logic [1:0]  hit_idx,
  output logic [15:0] score,
  output logic [15:0] high_score
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;

  localparam int unsigned CNT_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_DIV - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        hit_idx_q, hit_idx_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       high_score_q, high_score_d;
  logic              freeze_q, freeze_d;
  logic              game_over_q, game_over_d;
  logic              game_clk_q;
  logic              tick;
  logic              hit_evt;

  logic [8:0]        dino_pos_q, dino_pos_d;
  logic [2:0][8:0]   pos_q, pos_d;
  logic [2:0][2:0]   type_q, type_d;
  logic [2:0]        en_q, en_d;
  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        hit_q, hit_d;
  logic              s2_valid_q, s2_valid_d;

  assign tick = game_clk & ~game_clk_q;

  // BCD +1 with per-digit carry; 9999 is sticky.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    dino_pos_d = dino_pos_q;
    pos_d      = pos_q;
    type_d     = type_q;
    en_d       = en_q;
    if (tick) begin
      dino_pos_d = dino_pos;
      pos_d      = {danger_pos3, danger_pos2, danger_pos1};
      type_d     = {danger_type3, danger_type2, danger_type1};
      en_d       = {danger_en3, danger_en2, danger_en1};
    end
  end

  // All sums are 10 bits wide so that pos + width cannot wrap.
  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    logic [9:0] w, h, alt, x, y;
    assign x   = {1'b0, pos_q[gi]};
    assign y   = {1'b0, dino_pos_q};
    assign w   = type_q[gi][2] ? 10'(BIRD_W) : 10'(CACTUS_W);
    assign h   = type_q[gi][2] ? 10'(BIRD_H) : (type_q[gi][1] ? 10'd48 : 10'd32);
    assign alt = type_q[gi][2] ? ({4'd0, type_q[gi][1:0], 4'd0} + 10'd16) : 10'd0;
    assign hit_d[gi] = en_q[gi]
                     && (10'(DINO_X) < x + w) && (x < 10'(DINO_X + DINO_W))
                     && (y < alt + h) && (alt < y + 10'(DINO_H));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hit_idx_d    = hit_idx_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    freeze_d     = freeze_q;
    game_over_d  = game_over_q;
    hit_evt      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (s2_valid_q) begin
          if (|hit_q) begin
            hit_evt     = 1'b1;
            state_d     = ST_OVER;
            freeze_d    = 1'b1;
            game_over_d = 1'b1;
            hit_idx_d   = hit_q[0] ? 2'd1 : (hit_q[1] ? 2'd2 : 2'd3);
            if (score_q > high_score_q) high_score_d = score_q;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            score_d = bcd_inc(score_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          score_d     = 16'h0000;
          hit_idx_d   = 2'd0;
          freeze_d    = 1'b0;
          game_over_d = 1'b0;
        end
      end
    endcase
    // Ticks only enter the pipeline while running; a hit flushes anything behind it.
    s1_valid_d = tick && (state_q == ST_RUN) && !hit_evt;
    s2_valid_d = s1_valid_q && !hit_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hit_idx_q    <= 2'd0;
      score_q      <= 16'h0000;
      high_score_q <= 16'h0000;
      freeze_q     <= 1'b1;
      game_over_q  <= 1'b0;
      game_clk_q   <= 1'b0;
      dino_pos_q   <= '0;
      pos_q        <= '0;
      type_q       <= '0;
      en_q         <= '0;
      s1_valid_q   <= 1'b0;
      hit_q        <= '0;
      s2_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hit_idx_q    <= hit_idx_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      freeze_q     <= freeze_d;
      game_over_q  <= game_over_d;
      game_clk_q   <= game_clk;
      dino_pos_q   <= dino_pos_d;
      pos_q        <= pos_d;
      type_q       <= type_d;
      en_q         <= en_d;
      s1_valid_q   <= s1_valid_d;
      hit_q        <= hit_d;
      s2_valid_q   <= s2_valid_d;
    end
  end

  assign freeze     = freeze_q;
  assign game_over  = game_over_q;
  assign hit_idx    = hit_idx_q;
  assign score      = score_q;
  assign high_score = high_score_q;

endmodule

// File: tb/tb_dino_collision_ctrl.sv
// Bench for dino_collision_ctrl: two instances (score every 4 ticks / every tick)
// checked each cycle against a tick-queue game model, plus directed literal checks.
module tb_dino_collision_ctrl;
  localparam int DINO_X = 40, DINO_W = 40, DINO_H = 43;
  localparam int CACTUS_W = 16, BIRD_W = 32, BIRD_H = 24;

  logic clk = 1'b0, rst = 1'b0, game_clk = 1'b0, start = 1'b0;
  logic [8:0] dino_pos = '0;
  logic [8:0] danger_pos1 = '0, danger_pos2 = '0, danger_pos3 = '0;
  logic [2:0] danger_type1 = '0, danger_type2 = '0, danger_type3 = '0;
  logic danger_en1 = 1'b0, danger_en2 = 1'b0, danger_en3 = 1'b0;

  logic freeze_s, game_over_s, freeze_f, game_over_f;
  logic [1:0] hit_idx_s, hit_idx_f;
  logic [15:0] score_s, high_score_s, score_f, high_score_f;

  int n_total = 0, n_pass = 0;

  always #5 clk = ~clk;

  dino_collision_ctrl dut (
    .clk(clk), .rst(rst), .game_clk(game_clk), .start(start), .dino_pos(dino_pos),
    .danger_pos1(danger_pos1), .danger_pos2(danger_pos2), .danger_pos3(danger_pos3),
    .danger_type1(danger_type1), .danger_type2(danger_type2), .danger_type3(danger_type3),
    .danger_en1(danger_en1), .danger_en2(danger_en2), .danger_en3(danger_en3),
    .freeze(freeze_s), .game_over(game_over_s), .hit_idx(hit_idx_s),
    .score(score_s), .high_score(high_score_s));

  dino_collision_ctrl #(.SCORE_DIV(1)) dut_fast (
    .clk(clk), .rst(rst), .game_clk(game_clk), .start(start), .dino_pos(dino_pos),
    .danger_pos1(danger_pos1), .danger_pos2(danger_pos2), .danger_pos3(danger_pos3),
    .danger_type1(danger_type1), .danger_type2(danger_type2), .danger_type3(danger_type3),
    .danger_en1(danger_en1), .danger_en2(danger_en2), .danger_en3(danger_en3),
    .freeze(freeze_f), .game_over(game_over_f), .hit_idx(hit_idx_f),
    .score(score_f), .high_score(high_score_f));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  typedef struct { int due; int idx; } ev_t;
  ev_t evq[$];
  int  m_st = 0;              // 0 idle, 1 run, 2 over (shared: state does not depend on score)
  int  m_hidx = 0;
  int  m_score[2] = '{0, 0};
  int  m_hs[2]    = '{0, 0};
  int  m_cnt[2]   = '{0, 0};
  int  m_div[2]   = '{4, 1};
  int  cyc = 0;
  logic prev_gc = 1'b0;

  function automatic int slot_hit(input logic en, input logic [8:0] pos,
                                  input logic [2:0] ty, input logic [8:0] dp);
    int w, h, alt, x, y;
    logic [1:0] sub;
    if (!en) return 0;
    x = int'(pos);
    y = int'(dp);
    sub = ty[1:0];
    if (ty[2]) begin w = BIRD_W; h = BIRD_H; alt = 16 * (int'(sub) + 1); end
    else begin w = CACTUS_W; h = ty[1] ? 48 : 32; alt = 0; end
    return (DINO_X < x + w && x < DINO_X + DINO_W && y < alt + h && alt < y + DINO_H) ? 1 : 0;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_step();
    int st_pre;
    bit hit_now;
    ev_t e;
    if (rst) begin
      m_st = 0; m_hidx = 0; cyc = 0; prev_gc = 1'b0;
      evq.delete();
      for (int k = 0; k < 2; k++) begin m_score[k] = 0; m_hs[k] = 0; m_cnt[k] = 0; end
      return;
    end
    cyc++;
    st_pre = m_st;
    hit_now = 0;
    if (evq.size() > 0 && evq[0].due == cyc) begin
      e = evq.pop_front();
      if (e.idx != 0) begin
        m_st = 2; m_hidx = e.idx; hit_now = 1;
        evq.delete();
        for (int k = 0; k < 2; k++) if (m_score[k] > m_hs[k]) m_hs[k] = m_score[k];
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_cnt[k]++;
          if (m_cnt[k] == m_div[k]) begin
            m_cnt[k] = 0;
            if (m_score[k] < 9999) m_score[k]++;
          end
        end
      end
    end
    if (start && st_pre != 1) begin
      m_st = 1; m_hidx = 0;
      for (int k = 0; k < 2; k++) begin m_score[k] = 0; m_cnt[k] = 0; end
    end
    if (game_clk && !prev_gc && st_pre == 1 && !hit_now) begin
      e.due = cyc + 2;
      if (slot_hit(danger_en1, danger_pos1, danger_type1, dino_pos) != 0) e.idx = 1;
      else if (slot_hit(danger_en2, danger_pos2, danger_type2, dino_pos) != 0) e.idx = 2;
      else if (slot_hit(danger_en3, danger_pos3, danger_type3, dino_pos) != 0) e.idx = 3;
      else e.idx = 0;
      evq.push_back(e);
    end
    prev_gc = game_clk;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    logic [35:0] exp_s, exp_f;
    @(negedge clk);
    exp_s = {(m_st != 1), (m_st == 2), 2'(m_hidx), to_bcd(m_score[0]), to_bcd(m_hs[0])};
    exp_f = {(m_st != 1), (m_st == 2), 2'(m_hidx), to_bcd(m_score[1]), to_bcd(m_hs[1])};
    chk("cycle_div4", {freeze_s, game_over_s, hit_idx_s, score_s, high_score_s}, exp_s);
    chk("cycle_div1", {freeze_f, game_over_f, hit_idx_f, score_f, high_score_f}, exp_f);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_tick();
    @(posedge clk); #1 game_clk = 1'b1;
    @(posedge clk); #1 game_clk = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic en, input logic [2:0] ty, input logic [8:0] p);
    case (i)
      1: begin danger_en1 = en; danger_type1 = ty; danger_pos1 = p; end
      2: begin danger_en2 = en; danger_type2 = ty; danger_pos2 = p; end
      default: begin danger_en3 = en; danger_type3 = ty; danger_pos3 = p; end
    endcase
  endtask

  task automatic clear_slots();
    for (int i = 1; i <= 3; i++) set_slot(i, 1'b0, 3'd0, 9'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_freeze", freeze_s, 1'b1);
    chk("rst_game_over", game_over_s, 1'b0);
    chk("rst_hit_idx", hit_idx_s, 2'd0);
    chk("rst_score", score_s, 16'h0000);
    chk("rst_high", high_score_s, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    step(2);

    do_start();
    @(negedge clk);
    chk("start_freeze", freeze_s, 1'b0);
    chk("start_game_over", game_over_s, 1'b0);
    chk("start_score", score_s, 16'h0000);

    repeat (8) do_tick();
    step(3);
    chk("8tick_score_div4", score_s, 16'h0002);
    chk("8tick_score_div1", score_f, 16'h0008);

    // small cactus right in front of a grounded dino
    set_slot(1, 1'b1, 3'b000, 9'd60);
    dino_pos = 9'd0;
    do_tick();
    @(negedge clk); chk("hit_lat_t1", game_over_s, 1'b0);
    @(negedge clk); chk("hit_lat_t2", game_over_s, 1'b0);
    @(negedge clk); chk("hit_lat_t3", game_over_s, 1'b1);
    chk("hit_idx_slot1", hit_idx_s, 2'd1);
    chk("hit_high_div4", high_score_s, 16'h0002);
    chk("hit_high_div1", high_score_f, 16'h0008);
    do_tick(); do_tick(); step(3);
    chk("over_score_frozen", score_s, 16'h0002);
    chk("over_freeze", freeze_s, 1'b1);

    set_slot(1, 1'b0, 3'b000, 9'd60);
    do_start();
    set_slot(1, 1'b1, 3'b000, 9'd60);
    dino_pos = 9'd33;                 // just above a 32-high cactus
    do_tick();
    set_slot(1, 1'b1, 3'b000, 9'd80); // left edge touches dino right edge
    dino_pos = 9'd0;
    do_tick();
    step(3);
    chk("edge_no_hit", game_over_s, 1'b0);

    set_slot(1, 1'b1, 3'b101, 9'd50); // bird at altitude 32
    dino_pos = 9'd60;
    do_tick(); step(3);
    chk("bird_above_no_hit", game_over_s, 1'b0);
    dino_pos = 9'd0;
    do_tick(); step(3);
    chk("bird_hit", game_over_s, 1'b1);
    chk("bird_hit_idx", hit_idx_s, 2'd1);

    set_slot(1, 1'b1, 3'b010, 9'd200);
    set_slot(2, 1'b1, 3'b000, 9'd60);
    set_slot(3, 1'b1, 3'b101, 9'd50);
    do_start();
    do_tick(); step(3);
    chk("multi_hit_idx", hit_idx_s, 2'd2);

    // start and tick in the same clk while OVER: the tick is dropped
    @(posedge clk); #1 start = 1'b1; game_clk = 1'b1;
    @(posedge clk); #1 start = 1'b0; game_clk = 1'b0;
    step(4);
    chk("start_beats_tick", game_over_s, 1'b0);
    clear_slots();
    repeat (4) do_tick();
    step(3);
    chk("restart_score", score_s, 16'h0001);
    do_start();
    step(2);
    chk("start_in_run_ignored", score_s, 16'h0001);

    set_slot(2, 1'b1, 3'b000, 9'd60);
    do_tick(); step(3);
    chk("pre_rst_over", game_over_s, 1'b1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_over_freeze", freeze_s, 1'b1);
    chk("rst_over_game_over", game_over_s, 1'b0);
    chk("rst_over_high_div1", high_score_f, 16'h0000);

    do_start();
    do_tick();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    chk("inflight_dropped", game_over_s, 1'b0);
    chk("inflight_hit_idx", hit_idx_s, 2'd0);

    clear_slots();
    do_start();
    repeat (9999) do_tick();
    step(3);
    chk("sat_reach_div1", score_f, 16'h9999);
    chk("sat_reach_div4", score_s, 16'h2499);
    repeat (20) do_tick();
    step(3);
    chk("sat_hold_div1", score_f, 16'h9999);
    chk("sat_hold_div4", score_s, 16'h2504);
    set_slot(1, 1'b1, 3'b000, 9'd60);
    do_tick(); step(3);
    chk("sat_high_div1", high_score_f, 16'h9999);
    chk("sat_high_div4", high_score_s, 16'h2504);
    clear_slots();
    do_start();
    chk("sat_restart_score", score_f, 16'h0000);
    chk("sat_restart_high", high_score_f, 16'h9999);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dino_collision_ctrl.md
# dino_collision_ctrl

Game-state controller that sits directly downstream of the object controller and upstream of the picture generators and score display. Once per game tick it compares the dino hitbox against the three danger hitboxes and runs the IDLE/RUN/OVER game state machine. It also maintains a 4-digit BCD score and high score, and drives the freeze flag that stops object motion on a hit.

## Interface

Parameters:
- DINO_X, 40, dino left edge in screen x (dino x is fixed)
- DINO_W, 40, dino hitbox width
- DINO_H, 43, dino hitbox height
- CACTUS_W, 16, cactus width
- BIRD_W, 32, bird width
- BIRD_H, 24, bird height
- SCORE_DIV, 4, game ticks per score increment

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- game_clk  in  1  game tick level from GameClock; each rising edge is one tick
- start  in  1  one-clk pulse from the keyboard path (start/restart)
- dino_pos  in  9  dino height above ground in pixels (0 = on ground)
- danger_pos1..3  in  9 each  danger left edge in screen x
- danger_type1..3  in  3 each  danger type
- danger_en1..3  in  1 each  danger slot active
- freeze  out  1  high means ObjCtrl must hold all positions
- game_over  out  1  high in OVER
- hit_idx  out  2  slot that caused the last hit (1..3); 0 if none
- score  out  16  4 BCD digits
- high_score  out  16  4 BCD digits

## Operation

Danger geometry. Heights are measured upward from ground.
- type[2]=0 is a cactus: width CACTUS_W, altitude 0, height 48 if type[1] else 32.
- type[2]=1 is a bird: width BIRD_W, height BIRD_H, altitude 16*(type[1:0]+1), i.e. 16/32/48/64.

Hit test per slot i. The slot hits when all of the following hold:
- en_i = 1
- x overlap: DINO_X < pos_i + W_i and pos_i < DINO_X + DINO_W
- height overlap: dino_pos < alt_i + H_i and alt_i < dino_pos + DINO_H

Overlap rules:
- All overlap sums are computed at 10 bits, so pos + W never wraps.
- Overlaps are strict: edges that only touch do not hit.
- Disabled slots never hit.
- If several slots hit at once, hit_idx takes the lowest index.

FSM states: IDLE, RUN, OVER.
- IDLE: freeze=1, game_over=0. On start, clear score, clear tick counter, go to RUN.
- RUN: freeze=0. On each tick, evaluate the hit test.
  - On a hit, go to OVER and latch hit_idx. If score > high_score, set high_score = score.
  - With no hit, increment the tick counter. When it reaches SCORE_DIV-1, the counter wraps to 0 and score increments.
- OVER: freeze=1, game_over=1. On start, clear score, counter and hit_idx, go to RUN. high_score is kept.

Score rules:
- BCD increment with per-digit carry.
- Score saturates at 9999 and does not wrap.

Simultaneous events:
- start while in RUN is ignored.
- A tick and a start in the same clk in OVER: start wins, and that tick is not evaluated.

## Timing

- Tick detect: register game_clk_d; tick = game_clk & ~game_clk_d. Exactly one clk pulse per rising edge.
- Stage 1 (tick cycle T): register dino_pos, danger_pos*, danger_type*, danger_en* into a snapshot.
- Stage 2 (T+1): compute the three hit bits from the snapshot and register them.
- Stage 3 (T+2): FSM and score update. The freeze, game_over, hit_idx, score and high_score changes are visible at T+3.
- start acts in the clk cycle after it is sampled high and is independent of ticks.
- A hit pipeline in flight when the FSM leaves RUN is discarded.
- Reset values (all asynchronous): state=IDLE, freeze=1, game_over=0, hit_idx=0, score=0, high_score=0, tick counter=0, game_clk_d=0, pipeline valid bits=0.
- Reset mid-pipeline drops pending hits. No output glitches after reset deassertion.

## Test plan

- Reset, then pulse start → next cycle freeze=0, game_over=0, score=0000. After 8 ticks with no enabled dangers, score=0002.
- RUN, danger_en1=1, type=0, pos1=60, dino_pos=0 → game_over=1 and hit_idx=1 three clks after the tick. freeze stays 1 and score freezes.
- RUN, dino_pos=33 with a small cactus (H=32) at pos=60 → no hit. Same with pos=80 (pos = DINO_X+DINO_W, edge touch) → no hit.
- Bird type=3'b101 (alt 32) at pos=50: dino_pos=0 → hit. dino_pos=60 → no hit. Slots 2 and 3 hitting in the same tick → hit_idx=2.
- Score forced to 9999 → stays 9999 after 20 ticks. Hit with high_score=0 → high_score=9999. Restart → score=0000, high_score still 9999.
- Assert rst during OVER and during an in-flight hit → IDLE, freeze=1, score=0000, high_score=0000. The pending hit never appears.
